// File: rtl/fabric_scan_loader.sv
// fabric_scan_loader: streams configuration words onto the CLB or connection scan chain,
// reads them back non-destructively, and enables the fabric once a load completes.
module fabric_scan_loader #(
   parameter int FPGA_WIDTH     = 2,
   parameter int DATA_WIDTH     = 8,
   parameter int CLB_CHAIN_LEN  = 136,
   parameter int CONN_CHAIN_LEN = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic                  cfg_chain_sel,
   input  logic                  cfg_mode,
   input  logic                  cfg_abort,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  clb_scan_en,
   output logic                  clb_scan_in,
   input  logic                  clb_scan_out,
   output logic                  conn_scan_en,
   output logic                  conn_scan_in,
   input  logic                  conn_scan_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  fabric_run
);
   localparam int MAXLEN   = CLB_CHAIN_LEN > CONN_CHAIN_LEN ? CLB_CHAIN_LEN : CONN_CHAIN_LEN;
   localparam int CW       = $clog2(MAXLEN + 1);
   localparam int WW       = $clog2(DATA_WIDTH + 1);
   localparam int CLB_REM  = CLB_CHAIN_LEN % DATA_WIDTH == 0 ? DATA_WIDTH : CLB_CHAIN_LEN % DATA_WIDTH;
   localparam int CONN_REM = CONN_CHAIN_LEN % DATA_WIDTH == 0 ? DATA_WIDTH : CONN_CHAIN_LEN % DATA_WIDTH;

   if (FPGA_WIDTH < 1 || DATA_WIDTH < 2 || CLB_CHAIN_LEN < 1 || CONN_CHAIN_LEN < 1) begin : g_bad_param
      $error("fabric_scan_loader: invalid parameters");
   end

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, EMIT, DONE} state_t;

   state_t                state_q, state_d;
   logic                  sel_q, sel_d, mode_q, mode_d;
   logic                  err_q, err_d, fab_q, fab_d, prev_q, prev_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]         bcnt_q, bcnt_d;
   logic [WW-1:0]         wcnt_q, wcnt_d;

   logic [CW-1:0]         len;
   logic [WW-1:0]         sh;
   logic                  so, shifting, bit_in, last_bit, word_end;
   logic [DATA_WIDTH-1:0] cap;

   always_comb begin
      len      = sel_q ? CW'(CONN_CHAIN_LEN) : CW'(CLB_CHAIN_LEN);
      sh       = sel_q ? WW'(DATA_WIDTH - CONN_REM) : WW'(DATA_WIDTH - CLB_REM);
      so       = sel_q ? conn_scan_out : clb_scan_out;
      shifting = state_q == SHIFT && !cfg_abort;
      bit_in   = mode_q ? so : sr_q[0];
      last_bit = bcnt_q == len - CW'(1);
      word_end = wcnt_q == WW'(DATA_WIDTH - 1) || last_bit;
      cap      = {so, sr_q[DATA_WIDTH-1:1]};
      state_d  = state_q;
      sel_d    = sel_q;
      mode_d   = mode_q;
      err_d    = err_q;
      fab_d    = fab_q;
      prev_d   = prev_q;
      sr_d     = sr_q;
      bcnt_d   = bcnt_q;
      wcnt_d   = wcnt_q;
      if (state_q != IDLE && cfg_abort) begin
         state_d = IDLE;
         err_d   = 1'b1;
         fab_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cfg_start && !cfg_abort) begin
               sel_d   = cfg_chain_sel;
               mode_d  = cfg_mode;
               err_d   = 1'b0;
               prev_d  = fab_q;
               fab_d   = 1'b0;
               bcnt_d  = '0;
               wcnt_d  = '0;
               state_d = cfg_mode ? SHIFT : FETCH;
            end
            FETCH: if (cfg_valid) begin
               sr_d    = cfg_data;
               wcnt_d  = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               // a partial last readback word is right-justified as it leaves SHIFT
               sr_d    = mode_q ? (last_bit ? cap >> sh : cap) : sr_q >> 1;
               bcnt_d  = bcnt_q + CW'(1);
               wcnt_d  = wcnt_q + WW'(1);
               state_d = !word_end ? SHIFT : mode_q ? EMIT : last_bit ? DONE : FETCH;
               fab_d   = fab_q | (!mode_q && last_bit);
            end
            EMIT: if (rd_ready) begin
               wcnt_d  = '0;
               state_d = bcnt_q == len ? DONE : SHIFT;
               fab_d   = bcnt_q == len ? prev_q : fab_q;
            end
            default: state_d = IDLE;
         endcase
         if (cfg_start && state_q != IDLE) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         fab_q   <= 1'b0;
         prev_q  <= 1'b0;
         sr_q    <= '0;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         fab_q   <= fab_d;
         prev_q  <= prev_d;
         sr_q    <= sr_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      cfg_ready    = state_q == FETCH && !cfg_abort;
      rd_valid     = state_q == EMIT && !cfg_abort;
      rd_data      = state_q == EMIT ? sr_q : '0;
      clb_scan_en  = shifting && !sel_q;
      conn_scan_en = shifting && sel_q;
      clb_scan_in  = clb_scan_en && bit_in;
      conn_scan_in = conn_scan_en && bit_in;
      busy         = state_q != IDLE;
      done         = state_q == DONE && !cfg_abort;
      err          = err_q;
      fabric_run   = fab_q;
   end
endmodule

// File: doc/fabric_scan_loader.md
Name: fabric_scan_loader

Overview:
- Parametrised configuration controller for an FPGA_WIDTH x FPGA_WIDTH fabric. It replaces external bit-banging of the CLB and connection scan chains.
- Accepts configuration words over a valid/ready stream and serialises them onto the selected chain.
- Supports non-destructive readback: the chain recirculates while its bits are streamed out.
- Gates fabric operation via fabric_run until a load completes.

Parameters:
- FPGA_WIDTH, 2: tiles per row/column; informational only, chain lengths are set explicitly.
- DATA_WIDTH, 8: configuration/readback word width in bits.
- CLB_CHAIN_LEN, 136: total bits in the CLB scan chain.
- CONN_CHAIN_LEN, 512: total bits in the connection scan chain.

Ports:
- clk  in  1  scan/config clock; the fabric chains shift on this same clock.
- rst_n  in  1  reset.
- cfg_start  in  1  single-cycle request to begin an operation; sampled only in IDLE.
- cfg_chain_sel  in  1  0 = CLB chain, 1 = conn chain; sampled with cfg_start.
- cfg_mode  in  1  0 = write, 1 = readback; sampled with cfg_start.
- cfg_abort  in  1  terminate the current operation.
- cfg_data  in  DATA_WIDTH  write word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted on cfg_valid && cfg_ready.
- rd_data  out  DATA_WIDTH  readback word; bit 0 is the first bit out of the chain.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- clb_scan_en, clb_scan_in  out  1  CLB chain drive.
- clb_scan_out  in  1  CLB chain tail.
- conn_scan_en, conn_scan_in  out  1  conn chain drive.
- conn_scan_out  in  1  conn chain tail.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky; cleared by the next accepted cfg_start.
- fabric_run  out  1  fabric user-clock enable.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, including fabric_run (fabric unconfigured); state IDLE.
- Derived constants:
  - LEN = selected chain length.
  - NWORDS = ceil(LEN / DATA_WIDTH).
  - The last word carries LEN mod DATA_WIDTH valid bits (all bits if the remainder is 0); its upper bits are ignored in write mode and zero-filled in readback.
  - Bit counter width is $clog2(max(CLB_CHAIN_LEN, CONN_CHAIN_LEN) + 1).
- States: IDLE, FETCH, SHIFT, EMIT, DONE.
- IDLE:
  - cfg_start latches sel and mode, clears err, drives fabric_run = 0 and busy = 1.
  - Next state is FETCH in write mode, SHIFT in readback.
- FETCH (write mode):
  - cfg_ready = 1.
  - On handshake, load the shift register with cfg_data and go to SHIFT the next cycle.
  - cfg_valid low simply waits; chains hold because scan_en = 0.
- SHIFT:
  - Each cycle, drive exactly one bit: selected scan_en = 1, scan_in = the current LSB. The unselected chain's scan_en stays 0.
  - The shift register shifts right and the bit counter increments.
  - Readback: scan_in = selected scan_out (recirculate), and scan_out is captured into the MSB side of the word register.
  - After DATA_WIDTH bits, or when the chain end is reached: write mode goes to FETCH, or to DONE if the chain is complete; readback goes to EMIT.
  - No gaps occur within a word.
- EMIT (readback):
  - rd_valid = 1 with the word right-justified.
  - Hold until rd_ready; scan_en = 0 while stalled, so chain contents are preserved.
  - Then go to SHIFT, or to DONE after the last word.
- DONE:
  - done pulses for one cycle.
  - fabric_run = 1 if a write completed, or if fabric_run was already 1 before a readback.
  - Return to IDLE.
- Write latency: exactly LEN scan_en cycles per write. The first bit supplied ends at the far (last) chain position.
- Readback latency: LEN scan_en cycles total; the chain returns to its original contents.
- cfg_start while busy: ignored, err set, the operation in progress is unaffected.
- cfg_abort in any non-IDLE state: next cycle go to IDLE.
  - scan_en, cfg_ready, rd_valid drop immediately.
  - err = 1, fabric_run stays 0, no done pulse.
- cfg_abort and cfg_start in the same IDLE cycle: abort wins, nothing starts.
- Asynchronous reset mid-operation: immediate return to the reset values; the chain contents are undefined thereafter.
- Simultaneous cfg_valid in non-FETCH states: ignored (cfg_ready = 0).

Test Plan (CLB_CHAIN_LEN=20, CONN_CHAIN_LEN=16, DATA_WIDTH=8, behavioural chain model):
- CLB write of words 0xA5, 0x3C, 0x0F with gaps in cfg_valid:
  - exactly 20 clb_scan_en cycles, conn_scan_en never high;
  - last word uses only the low 4 bits;
  - model chain = expected 20-bit pattern;
  - one done pulse, fabric_run rises in the DONE cycle.
- CLB readback after that write:
  - rd_data = 0xA5, 0x3C, 0x0F (upper nibble 0);
  - chain contents unchanged afterwards.
- Conn write of 0xFF, 0x01 followed by readback with rd_ready low for 5 cycles after the first word:
  - no scan_en during the stall;
  - data returns 0xFF, 0x01.
- cfg_start pulsed mid-SHIFT: err = 1, the original load completes with correct data, done pulses.
- cfg_abort after 10 bits: busy = 0 next cycle, err = 1, fabric_run = 0, no done.
  - The next cfg_start clears err and a full reload succeeds.
- rst_n asserted mid-FETCH, asynchronously between clock edges: all outputs 0 immediately, state IDLE, and a new write completes correctly.
